// File: rtl/alu_mc_if.sv
// alu_mc_if: request/response bundle for the multi-cycle ALU.
//   Request : in_valid/in_ready handshake carrying alu_opcode, alu_src_sel,
//             a_data_in, b_data_in, imm_in, shift_amt.
//   Response: out_valid/out_ready handshake carrying data_out (2*DATA_W),
//             z_flag, carry_flag, ovf_flag, neg_flag, illegal_op.
//   Status  : busy.
// master modport: the issuing stage. slave modport: the ALU.
interface alu_mc_if #(
  parameter int unsigned DATA_W = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [3:0]            alu_opcode;
  logic                  alu_src_sel;
  logic [DATA_W-1:0]     a_data_in;
  logic [DATA_W-1:0]     b_data_in;
  logic [DATA_W-1:0]     imm_in;
  logic [DATA_W-1:0]     shift_amt;
  logic                  out_valid;
  logic                  out_ready;
  logic [2*DATA_W-1:0]   data_out;
  logic                  z_flag;
  logic                  carry_flag;
  logic                  ovf_flag;
  logic                  neg_flag;
  logic                  illegal_op;
  logic                  busy;

  modport master (
    output in_valid, alu_opcode, alu_src_sel, a_data_in, b_data_in, imm_in, shift_amt,
    output out_ready,
    input  in_ready, out_valid, data_out, z_flag, carry_flag, ovf_flag, neg_flag,
    input  illegal_op, busy
  );

  modport slave (
    input  in_valid, alu_opcode, alu_src_sel, a_data_in, b_data_in, imm_in, shift_amt,
    input  out_ready,
    output in_ready, out_valid, data_out, z_flag, carry_flag, ovf_flag, neg_flag,
    output illegal_op, busy
  );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: clocked multi-cycle ALU with valid/ready request and response handshakes.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - alu_mc_if.slave (operation request, registered result/flags, busy)
// One operation is captured in IDLE, evaluated in EXEC (or iterated in MUL),
// then held in DONE until out_ready. Reserved opcodes 1110/1111 flag illegal_op.
// Build option: define ALU_FAST_MUL_EN to compute MUL with a combinational
// multiplier in EXEC; otherwise MUL is a radix-2 shift-add, one bit per cycle.
module alu_mc #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = $clog2(DATA_W) + 1
) (
  input logic   clk,
  input logic   rst,
  alu_mc_if.slave bus
);

  localparam int unsigned W2  = 2 * DATA_W;
  localparam int unsigned Msb = DATA_W - 1;

  localparam logic [3:0] OpAdd  = 4'h0;
  localparam logic [3:0] OpSub  = 4'h1;
  localparam logic [3:0] OpMul  = 4'h2;
  localparam logic [3:0] OpAnd  = 4'h3;
  localparam logic [3:0] OpOr   = 4'h4;
  localparam logic [3:0] OpNot  = 4'h5;
  localparam logic [3:0] OpNor  = 4'h6;
  localparam logic [3:0] OpNand = 4'h7;
  localparam logic [3:0] OpXor  = 4'h8;
  localparam logic [3:0] OpXnor = 4'h9;
  localparam logic [3:0] OpInc  = 4'hA;
  localparam logic [3:0] OpDec  = 4'hB;
  localparam logic [3:0] OpShl  = 4'hC;
  localparam logic [3:0] OpShr  = 4'hD;

`ifdef ALU_FAST_MUL_EN
  typedef enum logic [1:0] {StIdle = 2'd0, StExec = 2'd1, StDone = 2'd3} state_e;
`else
  typedef enum logic [1:0] {StIdle = 2'd0, StExec = 2'd1, StMul = 2'd2, StDone = 2'd3} state_e;
`endif

  state_e state_q, state_d;

  logic [3:0]        op_q;
  logic [DATA_W-1:0] a_q, b_q, sh_q;
  logic [W2-1:0]     res_q;
  logic              z_q, c_q, o_q, n_q, ill_q;

  logic              accept, load_res;
  logic [DATA_W-1:0] bop;
  logic [W2-1:0]     mul_res;

  assign accept = (state_q == StIdle) && bus.in_valid;
  assign bop    = bus.alu_src_sel ? bus.imm_in : bus.b_data_in;

`ifdef ALU_FAST_MUL_EN
  assign mul_res  = {{DATA_W{1'b0}}, a_q} * {{DATA_W{1'b0}}, b_q};
  assign load_res = (state_q == StExec);
`else
  // prod_q = {accumulator, remaining multiplier bits}; each step conditionally
  // adds A into the upper half and shifts the whole product right by one.
  logic [W2-1:0]    prod_q, prod_step;
  logic [CNT_W-1:0] cnt_q;
  logic [DATA_W:0]  acc;
  logic             mul_last;

  assign mul_last  = (cnt_q == CNT_W'(DATA_W));
  assign acc       = {1'b0, prod_q[W2-1:DATA_W]} + (prod_q[0] ? {1'b0, a_q} : '0);
  assign prod_step = {acc, prod_q[DATA_W-1:1]};
  assign mul_res   = prod_q;
  assign load_res  = (state_q == StExec) || ((state_q == StMul) && mul_last);
`endif

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
`ifdef ALU_FAST_MUL_EN
          state_d = StExec;
`else
          state_d = (bus.alu_opcode == OpMul) ? StMul : StExec;
`endif
        end
      end
      StExec: state_d = StDone;
`ifndef ALU_FAST_MUL_EN
      StMul:  if (mul_last) state_d = StDone;
`endif
      StDone: if (bus.out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Result and flag evaluation on the captured operands.
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] diff, inc, dec, lres;
  logic [W2-1:0]     res;
  logic              c, o, ill, z, n;

  assign sum  = {1'b0, a_q} + {1'b0, b_q};
  assign diff = a_q - b_q;
  assign inc  = a_q + DATA_W'(1);
  assign dec  = a_q - DATA_W'(1);

  always_comb begin
    res  = '0;
    lres = '0;
    c    = 1'b0;
    o    = 1'b0;
    ill  = 1'b0;
    unique case (op_q)
      OpAdd: begin
        res = {{(DATA_W - 1){1'b0}}, sum};
        c   = sum[DATA_W];
        o   = (a_q[Msb] == b_q[Msb]) && (sum[Msb] != a_q[Msb]);
      end
      OpSub: begin
        res = {{DATA_W{1'b0}}, diff};
        c   = (a_q >= b_q);
        o   = (a_q[Msb] != b_q[Msb]) && (diff[Msb] != a_q[Msb]);
      end
      OpMul: res = mul_res;
      OpAnd, OpOr, OpNot, OpNor, OpNand, OpXor, OpXnor: begin
        unique case (op_q)
          OpAnd:   lres = a_q & b_q;
          OpOr:    lres = a_q | b_q;
          OpNot:   lres = ~a_q;
          OpNor:   lres = ~(a_q | b_q);
          OpNand:  lres = ~(a_q & b_q);
          OpXor:   lres = a_q ^ b_q;
          default: lres = ~(a_q ^ b_q);
        endcase
        res = {{DATA_W{1'b0}}, lres};
      end
      OpInc: begin
        res = {{DATA_W{1'b0}}, inc};
        c   = &a_q;
        o   = !a_q[Msb] && inc[Msb];
      end
      OpDec: begin
        res = {{DATA_W{1'b0}}, dec};
        c   = |a_q;
        o   = a_q[Msb] && !dec[Msb];
      end
      OpShl: res = (sh_q >= DATA_W'(W2)) ? '0 : ({{DATA_W{1'b0}}, a_q} << sh_q);
      OpShr: res = (sh_q >= DATA_W'(DATA_W)) ? '0 : {{DATA_W{1'b0}}, a_q >> sh_q};
      default: ill = 1'b1;
    endcase
    z = (res == '0);
    n = (op_q == OpMul) ? res[W2-1] : res[Msb];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      sh_q  <= '0;
      res_q <= '0;
      z_q   <= 1'b0;
      c_q   <= 1'b0;
      o_q   <= 1'b0;
      n_q   <= 1'b0;
      ill_q <= 1'b0;
`ifndef ALU_FAST_MUL_EN
      prod_q <= '0;
      cnt_q  <= '0;
`endif
    end else begin
      if (accept) begin
        op_q <= bus.alu_opcode;
        a_q  <= bus.a_data_in;
        b_q  <= bop;
        sh_q <= bus.shift_amt;
      end
`ifndef ALU_FAST_MUL_EN
      if (accept) begin
        prod_q <= {{DATA_W{1'b0}}, bop};
        cnt_q  <= '0;
      end else if ((state_q == StMul) && !mul_last) begin
        prod_q <= prod_step;
        cnt_q  <= cnt_q + CNT_W'(1);
      end
`endif
      if (load_res) begin
        res_q <= res;
        z_q   <= z;
        c_q   <= c;
        o_q   <= o;
        n_q   <= n;
        ill_q <= ill;
      end
    end
  end

  // in_ready is held low while reset is asserted so nothing is taken mid-reset.
  assign bus.in_ready   = (state_q == StIdle) && !rst;
  assign bus.out_valid  = (state_q == StDone);
`ifdef ALU_FAST_MUL_EN
  assign bus.busy       = (state_q == StExec);
`else
  assign bus.busy       = (state_q == StExec) || (state_q == StMul);
`endif
  assign bus.data_out   = res_q;
  assign bus.z_flag     = z_q;
  assign bus.carry_flag = c_q;
  assign bus.ovf_flag   = o_q;
  assign bus.neg_flag   = n_q;
  assign bus.illegal_op = ill_q;

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed and randomized stimulus for alu_mc (DATA_W=32) with a
// scoreboard queue filled at each accepted request and drained by a monitor on
// every response handshake. Reference results come from plain 64-bit arithmetic.
module tb_alu_mc;

  typedef struct packed {
    logic [63:0] data;
    logic        z;
    logic        c;
    logic        o;
    logic        n;
    logic        ill;
  } exp_t;

`ifdef ALU_FAST_MUL_EN
  localparam int MulLat = 2;
`else
  localparam int MulLat = 34;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rand_en = 1'b0;
  logic rdy_force = 1'b1;
  logic rnd_rdy = 1'b1;

  int n_checks = 0;
  int n_pass = 0;
  exp_t sb[$];

  alu_mc_if #(.DATA_W(32)) bus ();

  alu_mc #(.DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.out_ready = rand_en ? rnd_rdy : rdy_force;

  always @(posedge clk) begin
    #1;
    rnd_rdy = ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] sh);
    exp_t e;
    logic [31:0] t;
    longint s;
    bit arith;
    e = '0;
    t = '0;
    s = 0;
    arith = 0;
    case (op)
      4'h0: begin
        e.data = 64'(a) + 64'(b);
        e.c = e.data[32];
        s = longint'($signed(a)) + longint'($signed(b));
        arith = 1;
      end
      4'h1: begin
        t = a - b;
        e.data = 64'(t);
        e.c = (a >= b);
        s = longint'($signed(a)) - longint'($signed(b));
        arith = 1;
      end
      4'h2: e.data = 64'(a) * 64'(b);
      4'h3: begin t = a & b;    e.data = 64'(t); end
      4'h4: begin t = a | b;    e.data = 64'(t); end
      4'h5: begin t = ~a;       e.data = 64'(t); end
      4'h6: begin t = ~(a | b); e.data = 64'(t); end
      4'h7: begin t = ~(a & b); e.data = 64'(t); end
      4'h8: begin t = a ^ b;    e.data = 64'(t); end
      4'h9: begin t = ~(a ^ b); e.data = 64'(t); end
      4'hA: begin
        t = a + 32'd1;
        e.data = 64'(t);
        e.c = (a == 32'hFFFF_FFFF);
        s = longint'($signed(a)) + 1;
        arith = 1;
      end
      4'hB: begin
        t = a - 32'd1;
        e.data = 64'(t);
        e.c = (a != 0);
        s = longint'($signed(a)) - 1;
        arith = 1;
      end
      4'hC: e.data = (sh >= 64) ? 64'd0 : (64'(a) << sh);
      4'hD: e.data = (sh >= 32) ? 64'd0 : 64'(a >> sh);
      default: e.ill = 1'b1;
    endcase
    if (arith) e.o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    e.z = (e.data == 64'd0);
    e.n = (op == 4'h2) ? e.data[63] : e.data[31];
    return e;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: one pop per completed response handshake.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected response", bus.data_out, 64'hx);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("data_out", bus.data_out, e.data);
        chk("flags{z,c,o,n,ill}",
            {59'd0, bus.z_flag, bus.carry_flag, bus.ovf_flag, bus.neg_flag, bus.illegal_op},
            {59'd0, e.z, e.c, e.o, e.n, e.ill});
      end
    end
  end

  // Issue one op (called at posedge+1), push expectation at acceptance and
  // return once out_valid rises; latency counts the accept cycle as cycle 0.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic sel, input logic [31:0] sh,
                        input bit use_ovr, input exp_t ovr);
    int w;
    int lat;
    int bsy;
    bit rdy_seen;
    w = 0;
    while (!bus.in_ready && w < 200) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (!bus.in_ready) chk("in_ready wait timeout", bus.in_ready, 1);
    bus.alu_opcode  = op;
    bus.a_data_in   = a;
    bus.b_data_in   = b;
    bus.imm_in      = imm;
    bus.alu_src_sel = sel;
    bus.shift_amt   = sh;
    bus.in_valid    = 1'b1;
    @(posedge clk);
    sb.push_back(use_ovr ? ovr : model(op, a, sel ? imm : b, sh));
    #1;
    bus.in_valid  = 1'b0;
    bus.a_data_in = $urandom;
    bus.b_data_in = $urandom;
    bus.imm_in    = $urandom;
    bus.shift_amt = $urandom;
    lat = 1;
    bsy = 0;
    rdy_seen = 0;
    while (!bus.out_valid && lat < 200) begin
      if (bus.busy) bsy++;
      if (bus.in_ready) rdy_seen = 1;
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 64'(lat), (op == 4'h2) ? 64'(MulLat) : 64'd2);
    chk("busy cycles", 64'(bsy), (op == 4'h2) ? 64'(MulLat - 1) : 64'd1);
    chk("in_ready low while busy", 64'(rdy_seen), 64'd0);
  endtask

  initial begin
    exp_t ovr;
    int w;
    bus.in_valid    = 1'b0;
    bus.alu_opcode  = '0;
    bus.alu_src_sel = 1'b0;
    bus.a_data_in   = '0;
    bus.b_data_in   = '0;
    bus.imm_in      = '0;
    bus.shift_amt   = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset data_out", bus.data_out, 64'd0);
    chk("reset flags", {59'd0, bus.z_flag, bus.carry_flag, bus.ovf_flag, bus.neg_flag,
                        bus.illegal_op}, 64'd0);
    rst = 1'b0;
    #1;
    chk("in_ready after reset", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Directed cases with hand-derived expectations.
    ovr = '{data: 64'h1_0000_0000, z: 0, c: 1, o: 0, n: 0, ill: 0};
    run_op(4'h0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 32'h0, 1, ovr);
    ovr = '{data: 64'h0000_0000_FFFF_FFFE, z: 0, c: 0, o: 0, n: 1, ill: 0};
    run_op(4'h1, 32'd5, 32'h1234, 32'd7, 1'b1, 32'h0, 1, ovr);
    ovr = '{data: 64'd2, z: 0, c: 1, o: 0, n: 0, ill: 0};
    run_op(4'h1, 32'd7, 32'h1234, 32'd5, 1'b1, 32'h0, 1, ovr);
    ovr = '{data: 64'hFFFF_FFFE_0000_0001, z: 0, c: 0, o: 0, n: 1, ill: 0};
    run_op(4'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, 32'h0, 1, ovr);
    ovr = '{data: 64'h0, z: 1, c: 0, o: 0, n: 0, ill: 1};
    run_op(4'hF, 32'h55, 32'h66, 32'h0, 1'b0, 32'h0, 1, ovr);
    ovr = '{data: 64'h8000_0000_0000_0000, z: 0, c: 0, o: 0, n: 0, ill: 0};
    run_op(4'hC, 32'h1, 32'h0, 32'h0, 1'b0, 32'd63, 1, ovr);
    ovr = '{data: 64'h0, z: 1, c: 0, o: 0, n: 0, ill: 0};
    run_op(4'hD, 32'hDEAD_BEEF, 32'h0, 32'h0, 1'b0, 32'd40, 1, ovr);

    // Backpressure: result must hold while requests are ignored.
    w = 0;
    while (!bus.in_ready && w < 50) begin
      @(posedge clk);
      #1;
      w++;
    end
    rdy_force = 1'b0;
    ovr = '{data: 64'h0F0F, z: 0, c: 0, o: 0, n: 0, ill: 0};
    run_op(4'h8, 32'hF0F0, 32'hFFFF, 32'h0, 1'b0, 32'h0, 1, ovr);
    for (int i = 0; i < 10; i++) begin
      chk("stall data_out", bus.data_out, 64'h0F0F);
      chk("stall out_valid", 64'(bus.out_valid), 64'd1);
      bus.in_valid   = i[0];
      bus.alu_opcode = 4'(i);
      bus.a_data_in  = $urandom;
      @(posedge clk);
      #1;
    end

    // Request raised together with out_ready in DONE: taken one cycle later.
    bus.alu_opcode  = 4'h0;
    bus.a_data_in   = 32'd1;
    bus.b_data_in   = 32'd1;
    bus.alu_src_sel = 1'b0;
    bus.in_valid    = 1'b1;
    rdy_force       = 1'b1;
    chk("in_ready in DONE", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("in_ready after DONE", 64'(bus.in_ready), 64'd1);
    chk("out_valid after DONE", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    sb.push_back('{data: 64'd2, z: 0, c: 0, o: 0, n: 0, ill: 0});
    #1;
    bus.in_valid = 1'b0;
    chk("busy after delayed accept", 64'(bus.busy), 64'd1);
    w = 0;
    while (!bus.in_ready && w < 50) begin
      @(posedge clk);
      #1;
      w++;
    end

    // Reset in the middle of a multiply discards it.
    bus.alu_opcode = 4'h2;
    bus.a_data_in  = 32'h1234_5678;
    bus.b_data_in  = 32'h9ABC_DEF0;
    bus.in_valid   = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (14) @(posedge clk);
    #1;
`ifndef ALU_FAST_MUL_EN
    chk("busy mid multiply", 64'(bus.busy), 64'd1);
`endif
    rst = 1'b1;
    #1;
    chk("reset out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset data_out", bus.data_out, 64'd0);
    chk("reset busy", 64'(bus.busy), 64'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("in_ready after reset", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    ovr = '{data: 64'd5, z: 0, c: 0, o: 0, n: 0, ill: 0};
    run_op(4'h0, 32'd2, 32'd3, 32'h0, 1'b0, 32'h0, 1, ovr);

    // Randomized ops against the model with random response backpressure.
    rand_en = 1'b1;
    for (int i = 0; i < 250; i++) begin
      logic [31:0] sh;
      sh = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 70));
      run_op(4'($urandom_range(0, 15)), pick(), pick(), pick(), 1'($urandom_range(0, 1)), sh,
             0, '0);
    end

    w = 0;
    while (sb.size() != 0 && w < 500) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("scoreboard drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
